// File: rtl/modulo_controle_rolhas.sv
// modulo_controle_rolhas: cork stock controller with a 4-phase dispenser refill handshake
module modulo_controle_rolhas #(
    parameter int MAX_ROLHAS = 99,
    parameter int LOTE       = 15,
    parameter int LIMIAR     = 5,
    parameter int TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       vedar,
    input  logic       repor,
    input  logic       dispensador_pronto,
    output logic       req_dispensador,
    output logic [6:0] m_out,
    output logic       enable_reg,
    output logic       vedacao_ok,
    output logic       falha_vedacao,
    output logic       alarme_vazio,
    output logic       alarme_dispensador
);
    typedef enum logic [1:0] {OPERA, REQUISITA, LIBERA} state_t;
    state_t state, state_next;
    logic prev_vedar, prev_repor, ev, er, ack, dec, alarme_next;
    logic [7:0] soma;
    logic [6:0] count_next;
    logic [9:0] tempo, tempo_next;
    always_ff @(posedge clk) begin
        if (!clr) begin
            state              <= OPERA;
            prev_vedar         <= 1'b1;
            prev_repor         <= 1'b1;
            tempo              <= '0;
            m_out              <= '0;
            req_dispensador    <= 1'b0;
            enable_reg         <= 1'b0;
            vedacao_ok         <= 1'b0;
            falha_vedacao      <= 1'b0;
            alarme_vazio       <= 1'b1;
            alarme_dispensador <= 1'b0;
        end else begin
            state              <= state_next;
            prev_vedar         <= vedar;
            prev_repor         <= repor;
            tempo              <= tempo_next;
            m_out              <= count_next;
            req_dispensador    <= state_next == REQUISITA;
            enable_reg         <= count_next != m_out;
            vedacao_ok         <= dec;
            falha_vedacao      <= ev && m_out == 7'd0;
            alarme_vazio       <= count_next == 7'd0;
            alarme_dispensador <= alarme_next;
        end
    end
    always_comb begin
        state_next = state;
        case (state)
            OPERA:     if (count_next <= 7'(LIMIAR) || er) state_next = REQUISITA;
            REQUISITA: if (dispensador_pronto) state_next = LIBERA;
            LIBERA:    if (!dispensador_pronto) state_next = OPERA;
            default:   state_next = OPERA;
        endcase
    end
    // Count math in 8 bits so a batch on top of a high stock saturates instead of wrapping.
    always_comb begin
        ev          = vedar & ~prev_vedar;
        er          = repor & ~prev_repor;
        ack         = state == REQUISITA && dispensador_pronto;
        dec         = ev && m_out != 7'd0;
        soma        = {1'b0, m_out} - {7'd0, dec} + (ack ? 8'(LOTE) : 8'd0);
        count_next  = soma > 8'(MAX_ROLHAS) ? 7'(MAX_ROLHAS) : soma[6:0];
        tempo_next  = state != REQUISITA ? 10'd0 : (tempo == 10'(TIMEOUT) ? tempo : tempo + 10'd1);
        alarme_next = ack ? 1'b0 : (alarme_dispensador || (state == REQUISITA && tempo_next == 10'(TIMEOUT)));
    end
endmodule
